// File: rtl/probe_frame_sender.sv
// Probe frame generator: bursts of fixed-length Ethernet test frames on the MAC TX byte port.
// Define PROBE_TIMESTAMP_EN to carry a latched 32-bit tx_clk timestamp in bytes 16-19.
module probe_frame_sender #(
  parameter int unsigned FRAME_LEN   = 60,
  parameter int unsigned GAP_CYCLES  = 100,
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC     = 48'h004e46324300,
  parameter logic [15:0] ETH_TYPE    = 16'h88B5
) (
  input  logic        tx_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] frame_count,
  output logic        conf_tx_en,
  output logic        conf_tx_jumbo_en,
  output logic        conf_tx_no_gen_crc,
  output logic [7:0]  mac_tx_data,
  output logic        mac_tx_dvld,
  input  logic        mac_tx_ack,
  output logic        busy,
  output logic [15:0] seq,
  output logic [7:0]  timeout_cnt
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic             JUMBO    = (FRAME_LEN > 1514);

  typedef enum logic [1:0] {IDLE, GAP, WAIT_ACK, DATA} state_t;

  state_t           state, state_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic [ACK_W-1:0] ack_cnt, ack_cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [15:0]      remaining, remaining_n;
  logic [15:0]      seq_n;
  logic [7:0]       timeout_cnt_n;
  logic [7:0]       data_n;
  logic             dvld_n;
  logic             enable_q;

`ifdef PROBE_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_latch;
  logic        capture;
`endif

  // Byte i of the frame; header fields are sent most significant byte first.
  function automatic logic [7:0] frame_byte(input logic [15:0] i);
    int unsigned k;
    logic [7:0]  b;
    k = 32'(i);
    b = i[7:0];
    if (k < 6)       b = 8'(DST_MAC >> (8 * (5 - k)));
    else if (k < 12) b = 8'(SRC_MAC >> (8 * (11 - k)));
    else if (k < 14) b = 8'(ETH_TYPE >> (8 * (13 - k)));
    else if (k < 16) b = 8'(seq >> (8 * (15 - k)));
`ifdef PROBE_TIMESTAMP_EN
    else if (k < 20) b = 8'(ts_latch >> (8 * (19 - k)));
`endif
    return b;
  endfunction

  always_comb begin
    state_n       = state;
    gap_cnt_n     = gap_cnt;
    ack_cnt_n     = ack_cnt;
    idx_n         = idx;
    remaining_n   = remaining;
    seq_n         = seq;
    timeout_cnt_n = timeout_cnt;
    dvld_n        = 1'b0;
    data_n        = 8'h00;
`ifdef PROBE_TIMESTAMP_EN
    capture       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (enable && !enable_q) begin
          remaining_n = frame_count;
          gap_cnt_n   = '0;
          state_n     = GAP;
        end
      end
      GAP: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (gap_cnt == GAP_LAST) begin
          state_n   = WAIT_ACK;
          ack_cnt_n = '0;
          dvld_n    = 1'b1;
          data_n    = frame_byte(16'd0);
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end
      WAIT_ACK: begin
        if (mac_tx_ack) begin
          state_n = DATA;
          idx_n   = IDX_W'(1);
          dvld_n  = 1'b1;
          data_n  = frame_byte(16'd1);
`ifdef PROBE_TIMESTAMP_EN
          capture = 1'b1;
`endif
        end else if (ack_cnt == ACK_LAST) begin
          // Aborted frame: the sequence number is reused on the retry.
          state_n   = GAP;
          gap_cnt_n = '0;
          if (timeout_cnt != 8'hFF) timeout_cnt_n = timeout_cnt + 8'd1;
        end else begin
          ack_cnt_n = ack_cnt + 1'b1;
          dvld_n    = 1'b1;
          data_n    = frame_byte(16'd0);
        end
      end
      DATA: begin
        if (idx == IDX_LAST) begin
          seq_n     = seq + 16'd1;
          gap_cnt_n = '0;
          if (remaining != 16'd0) remaining_n = remaining - 16'd1;
          state_n = (remaining == 16'd1 || !enable) ? IDLE : GAP;
        end else begin
          idx_n  = idx + 1'b1;
          dvld_n = 1'b1;
          data_n = frame_byte(16'(idx) + 16'd1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (reset) begin
      state              <= IDLE;
      gap_cnt            <= '0;
      ack_cnt            <= '0;
      idx                <= '0;
      remaining          <= '0;
      seq                <= '0;
      timeout_cnt        <= '0;
      mac_tx_dvld        <= 1'b0;
      mac_tx_data        <= 8'h00;
      busy               <= 1'b0;
      conf_tx_en         <= 1'b0;
      conf_tx_jumbo_en   <= 1'b0;
      conf_tx_no_gen_crc <= 1'b0;
    end else begin
      state              <= state_n;
      gap_cnt            <= gap_cnt_n;
      ack_cnt            <= ack_cnt_n;
      idx                <= idx_n;
      remaining          <= remaining_n;
      seq                <= seq_n;
      timeout_cnt        <= timeout_cnt_n;
      mac_tx_dvld        <= dvld_n;
      mac_tx_data        <= data_n;
      busy               <= (state_n != IDLE);
      conf_tx_en         <= 1'b1;
      conf_tx_jumbo_en   <= JUMBO;
      conf_tx_no_gen_crc <= 1'b0;
    end
  end

  // Tracks enable through reset too, so a level held high across reset does not start a burst.
  always_ff @(posedge tx_clk) begin
    enable_q <= enable;
  end

`ifdef PROBE_TIMESTAMP_EN
  always_ff @(posedge tx_clk) begin
    if (reset) begin
      ts_cnt   <= '0;
      ts_latch <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (capture) ts_latch <= ts_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_probe_frame_sender.sv
// Self-checking bench for probe_frame_sender: directed bursts with randomized ack timing
// against a frame-level reference model.
module tb_probe_frame_sender;

  localparam int FL  = 60;
  localparam int GAP = 100;
  localparam int ATO = 16;
  localparam logic [47:0] DST   = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SRC   = 48'h004e46324300;
  localparam logic [15:0] ETYPE = 16'h88B5;

  logic        tx_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] frame_count;
  logic        mac_tx_ack;
  logic        conf_tx_en;
  logic        conf_tx_jumbo_en;
  logic        conf_tx_no_gen_crc;
  logic [7:0]  mac_tx_data;
  logic        mac_tx_dvld;
  logic        busy;
  logic [15:0] seq;
  logic [7:0]  timeout_cnt;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          rst_cyc  = 0;
  logic [15:0] m_seq;
  logic [7:0]  m_tmo;
  int          m_rem;
  bit          idle;

  always #5 tx_clk = ~tx_clk;

  probe_frame_sender #(
    .FRAME_LEN  (FL),
    .GAP_CYCLES (GAP),
    .ACK_TIMEOUT(ATO)
  ) dut (
    .tx_clk            (tx_clk),
    .reset             (reset),
    .enable            (enable),
    .frame_count       (frame_count),
    .conf_tx_en        (conf_tx_en),
    .conf_tx_jumbo_en  (conf_tx_jumbo_en),
    .conf_tx_no_gen_crc(conf_tx_no_gen_crc),
    .mac_tx_data       (mac_tx_data),
    .mac_tx_dvld       (mac_tx_dvld),
    .mac_tx_ack        (mac_tx_ack),
    .busy              (busy),
    .seq               (seq),
    .timeout_cnt       (timeout_cnt)
  );

  // Outputs are observed and inputs driven at the falling edge, mid-cycle.
  task automatic step();
    @(negedge tx_clk);
    cyc++;
  endtask

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [15:0] s, input logic [31:0] ts);
    logic [159:0] hdr;
    hdr = {DST, SRC, ETYPE, s, ts};
`ifndef PROBE_TIMESTAMP_EN
    hdr[31:0] = 32'h10111213;
`endif
    if (i < 20) return hdr[159 - 8*i -: 8];
    return i[7:0];
  endfunction

  task automatic apply_stimulus(input int count);
    enable = 1'b0;
    step();
    frame_count = 16'(count);
    m_rem       = count;
    enable      = 1'b1;
    step();
    frame_count = 16'($urandom);
    check_output("start_busy", busy, 1);
  endtask

  task automatic expect_quiet(input int n);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      if (mac_tx_dvld !== 1'b0 || busy !== 1'b0) hits++;
      mac_tx_ack = 1'($urandom);
      step();
    end
    check_output("quiet", hits, 0);
  endtask

  // One frame attempt starting in the first idle cycle before it; ack_delay > ATO means no ack.
  task automatic expect_frame(input int ack_delay, input int drop_byte, input int reset_byte,
                              output bit went_idle);
    int          waited;
    logic [31:0] ts_exp;
    went_idle = 1'b0;
    waited    = 0;
    while (mac_tx_dvld !== 1'b1 && waited < 4 * GAP) begin
      waited++;
      mac_tx_ack = 1'($urandom);
      step();
    end
    check_output("gap_len", waited, GAP);
    if (mac_tx_dvld !== 1'b1) return;

    for (int j = 1; j <= ack_delay && j <= ATO; j++) begin
      check_output("byte0_dvld", mac_tx_dvld, 1);
      check_output("byte0_data", mac_tx_data, exp_byte(0, m_seq, 32'd0));
      check_output("seq_out", seq, m_seq);
      mac_tx_ack = (j == ack_delay);
      step();
    end

    if (ack_delay > ATO) begin
      check_output("timeout_dvld", mac_tx_dvld, 0);
      if (m_tmo != 8'hFF) m_tmo++;
      check_output("timeout_cnt", timeout_cnt, m_tmo);
      check_output("timeout_seq", seq, m_seq);
      check_output("timeout_busy", busy, 1);
      return;
    end

    ts_exp = 32'(cyc - 1 - rst_cyc);
    for (int k = 1; k < FL; k++) begin
      check_output("data_dvld", mac_tx_dvld, 1);
      check_output("data_byte", mac_tx_data, exp_byte(k, m_seq, ts_exp));
      mac_tx_ack = 1'($urandom);
      if (k == drop_byte) enable = 1'b0;
      if (k == reset_byte) begin
        reset = 1'b1;
        step();
        m_seq = 16'd0;
        m_tmo = 8'd0;
        check_output("rst_dvld", mac_tx_dvld, 0);
        check_output("rst_data", mac_tx_data, 0);
        check_output("rst_seq", seq, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_tmo", timeout_cnt, 0);
        check_output("rst_conf_en", conf_tx_en, 0);
        reset     = 1'b0;
        rst_cyc   = cyc;
        went_idle = 1'b1;
        return;
      end
      step();
    end

    check_output("end_dvld", mac_tx_dvld, 0);
    m_seq++;
    went_idle = (m_rem == 1) || !enable;
    if (m_rem != 0) m_rem--;
    check_output("end_seq", seq, m_seq);
    check_output("end_busy", busy, !went_idle);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    mac_tx_ack  = 1'b0;
    frame_count = 16'd0;
    m_seq       = 16'd0;
    m_tmo       = 8'd0;
    m_rem       = 0;
    repeat (3) step();

    check_output("rst_dvld", mac_tx_dvld, 0);
    check_output("rst_data", mac_tx_data, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_seq", seq, 0);
    check_output("rst_tmo", timeout_cnt, 0);
    check_output("rst_conf_en", conf_tx_en, 0);
    check_output("rst_jumbo", conf_tx_jumbo_en, 0);
    check_output("rst_nocrc", conf_tx_no_gen_crc, 0);

    reset   = 1'b0;
    rst_cyc = cyc;
    step();
    check_output("conf_en", conf_tx_en, 1);
    check_output("conf_jumbo", conf_tx_jumbo_en, 0);
    check_output("conf_nocrc", conf_tx_no_gen_crc, 0);
    check_output("idle_busy", busy, 0);
    expect_quiet(5);

    $display("[TB] burst of three frames, ack immediate");
    apply_stimulus(3);
    for (int f = 0; f < 3; f++) expect_frame(1, -1, -1, idle);
    check_output("burst3_seq", seq, 3);
    expect_quiet(2 * GAP);

    $display("[TB] ack delayed seven cycles");
    apply_stimulus(1);
    expect_frame(7, -1, -1, idle);
    check_output("single_idle", idle, 1);
    expect_quiet(GAP + 10);

    $display("[TB] ack timeout then retry");
    apply_stimulus(1);
    expect_frame(ATO + 1, -1, -1, idle);
    expect_frame(int'($urandom_range(1, 10)), -1, -1, idle);
    expect_quiet(GAP + 10);

    $display("[TB] unlimited burst, enable dropped at byte 30");
    apply_stimulus(0);
    expect_frame(int'($urandom_range(1, 10)), -1, -1, idle);
    expect_frame(int'($urandom_range(1, 10)), 30, -1, idle);
    check_output("drop30_idle", idle, 1);
    expect_quiet(2 * GAP);

    $display("[TB] enable dropped on the last byte");
    apply_stimulus(0);
    expect_frame(int'($urandom_range(1, 10)), FL - 1, -1, idle);
    expect_quiet(GAP + 10);

    $display("[TB] enable dropped during the gap");
    apply_stimulus(5);
    repeat (10) step();
    enable = 1'b0;
    step();
    check_output("gap_abort_busy", busy, 0);
    expect_quiet(2 * GAP);

    $display("[TB] reset during byte 25");
    apply_stimulus(0);
    expect_frame(int'($urandom_range(1, 10)), -1, 25, idle);
    step();
    check_output("rerun_conf_en", conf_tx_en, 1);
    expect_quiet(GAP + 10);
    apply_stimulus(1);
    expect_frame(int'($urandom_range(1, 10)), -1, -1, idle);
    check_output("restart_seq", seq, 1);

    $display("[TB] randomized burst");
    apply_stimulus(int'($urandom_range(1, 3)));
    idle = 1'b0;
    for (int f = 0; f < 8 && !idle; f++) expect_frame(int'($urandom_range(1, 20)), -1, -1, idle);
    check_output("rand_idle", idle, 1);
    expect_quiet(GAP + 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
